// File: rtl/smallcalc_ctrl_if.sv
// Register-file bus between the calculator sequencer and its register file:
// one write port and two combinational read ports.
interface smallcalc_ctrl_if #(
  parameter int DW = 5,
  parameter int AW = 2
);
  logic          rea;
  logic          reb;
  logic [AW-1:0] raa;
  logic [AW-1:0] rab;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] din;
  logic [DW-1:0] douta;
  logic [DW-1:0] doutb;

  // The sequencer drives addresses, enables and write data; the RF returns read data.
  modport master (
    output rea, reb, raa, rab, we, wa, din,
    input  douta, doutb
  );

  modport slave (
    input  rea, reb, raa, rab, we, wa, din,
    output douta, doutb
  );
endinterface

// File: rtl/smallcalc_ctrl.sv
// Moore sequencer for the small calculator: loads two operands into the RF,
// reads them back, runs a DW-bit ALU, writes the result and re-reads it.
module smallcalc_ctrl #(
  parameter int DW    = 5,
  parameter int AW    = 2,
  parameter int REG_A = 0,
  parameter int REG_B = 1,
  parameter int REG_R = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go,
  input  logic [1:0]    op,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  smallcalc_ctrl_if.master rf,
  output logic [DW-1:0] result,
  output logic          ovf,
  output logic          busy,
  output logic          done,
  output logic [2:0]    fsm_state
);

  localparam logic [AW-1:0] ADDR_A = AW'(REG_A);
  localparam logic [AW-1:0] ADDR_B = AW'(REG_B);
  localparam logic [AW-1:0] ADDR_R = AW'(REG_R);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    READ   = 3'd3,
    EXEC   = 3'd4,
    OUT    = 3'd5,
    DONE_S = 3'd6
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [1:0]    op_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [DW-1:0] opa;
  logic [DW-1:0] opb;
  logic [DW:0]   sum6;
  logic          we_raw;
  logic          rea_raw;
  logic          reb_raw;

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // go is only honoured in IDLE, so requests arriving while busy are dropped.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go) state_next = LOAD_A;
      LOAD_A:  state_next = LOAD_B;
      LOAD_B:  state_next = READ;
      READ:    state_next = EXEC;
      EXEC:    state_next = OUT;
      OUT:     state_next = DONE_S;
      DONE_S:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ALU works one bit wider so the top bit is the carry (add) or borrow (sub).
  always_comb begin
    sum6 = '0;
    case (op_q)
      2'b00: sum6 = {1'b0, opa} + {1'b0, opb};
      2'b01: sum6 = {1'b0, opa} - {1'b0, opb};
      2'b10: sum6 = {1'b0, opa & opb};
      2'b11: sum6 = {1'b0, opa | opb};
      default: sum6 = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      opa    <= '0;
      opb    <= '0;
      result <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            op_q <= op;
            a_q  <= in_a;
            b_q  <= in_b;
          end
        end
        READ: begin
          opa <= rf.douta;
          opb <= rf.doutb;
        end
        EXEC:    ovf <= op_q[1] ? 1'b0 : sum6[DW];
        OUT:     result <= rf.douta;
        default: ;
      endcase
    end
  end

  always_comb begin
    we_raw  = 1'b0;
    rea_raw = 1'b0;
    reb_raw = 1'b0;
    rf.raa  = '0;
    rf.rab  = '0;
    rf.wa   = '0;
    rf.din  = '0;
    busy    = (state != IDLE);
    done    = (state == DONE_S);
    case (state)
      LOAD_A: begin
        we_raw = 1'b1;
        rf.wa  = ADDR_A;
        rf.din = a_q;
      end
      LOAD_B: begin
        we_raw = 1'b1;
        rf.wa  = ADDR_B;
        rf.din = b_q;
      end
      READ: begin
        rea_raw = 1'b1;
        reb_raw = 1'b1;
        rf.raa  = ADDR_A;
        rf.rab  = ADDR_B;
      end
      EXEC: begin
        we_raw = 1'b1;
        rf.wa  = ADDR_R;
        rf.din = sum6[DW-1:0];
      end
      OUT: begin
        rea_raw = 1'b1;
        rf.raa  = ADDR_R;
      end
      default: ;
    endcase
    // Enables are masked by reset so the RF cannot be written while rst_n is low.
    rf.we  = we_raw & rst_n;
    rf.rea = rea_raw & rst_n;
    rf.reb = reb_raw & rst_n;
  end

endmodule

// File: tb/tb_smallcalc_ctrl.sv
// Bench for smallcalc_ctrl: behavioural RF model, directed operations with
// hand-computed results, and a monitor that checks RF writes and done results.
module tb_smallcalc_ctrl;
  localparam int DW = 5;
  localparam int AW = 2;

  logic          clk;
  logic          rst_n;
  logic          go;
  logic [1:0]    op;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [DW-1:0] result;
  logic          ovf;
  logic          busy;
  logic          done;
  logic [2:0]    fsm_state;

  smallcalc_ctrl_if #(.DW(DW), .AW(AW)) rf_if ();

  smallcalc_ctrl #(.DW(DW), .AW(AW), .REG_A(0), .REG_B(1), .REG_R(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (go),
    .op        (op),
    .in_a      (in_a),
    .in_b      (in_b),
    .rf        (rf_if),
    .result    (result),
    .ovf       (ovf),
    .busy      (busy),
    .done      (done),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file model: not reset, combinational reads
  logic [DW-1:0] rf_mem [4];
  initial for (int i = 0; i < 4; i++) rf_mem[i] = '0;
  always @(posedge clk) if (rf_if.we === 1'b1) rf_mem[rf_if.wa] <= rf_if.din;
  assign rf_if.douta = rf_mem[rf_if.raa];
  assign rf_if.doutb = rf_mem[rf_if.rab];

  // scoreboard
  logic [DW:0]      exp_q[$];   // {ovf, result}
  logic [AW+DW-1:0] wr_q[$];    // {wa, din}
  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rf_if.we === 1'b1) begin
      if (wr_q.size() == 0) check("unexpected_write", {rf_if.wa, rf_if.din}, 32'hFFFF);
      else                  check("rf_write", {rf_if.wa, rf_if.din}, wr_q.pop_front());
    end
    if (done === 1'b1) begin
      done_seen++;
      if (exp_q.size() == 0) check("unexpected_done", {ovf, result}, 32'hFFFF);
      else                   check("result_ovf", {ovf, result}, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic expect_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] r, input logic v);
    wr_q.push_back({2'd0, a});
    wr_q.push_back({2'd1, b});
    wr_q.push_back({2'd2, r});
    exp_q.push_back({v, r});
  endtask

  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [1:0] o,
                        input logic [DW-1:0] r, input logic v);
    int edges;
    bit found;
    expect_op(a, b, r, v);
    @(negedge clk);
    in_a = a; in_b = b; op = o; go = 1'b1;
    @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    in_a = ~a;
    check("busy_after_go", busy, 1);
    edges = 0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done === 1'b1) begin
        found = 1;
        break;
      end
    end
    if (!found) check("done_timeout", 0, 1);
    else        check("latency_edges", edges, 5);
    @(negedge clk);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; go = 1'b1; op = 2'b00; in_a = '0; in_b = '0;

    // T1: reset with go held high
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_we", rf_if.we, 0);
    check("rst_rea", rf_if.rea, 0);
    check("rst_reb", rf_if.reb, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_ovf", ovf, 0);
    go = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_go", busy, 0);

    // T2-T4: arithmetic and logic
    run_op(5'd7,  5'd9,  2'b00, 5'd16, 1'b0);
    run_op(5'd20, 5'd15, 2'b00, 5'd3,  1'b1);
    run_op(5'd5,  5'd9,  2'b01, 5'd28, 1'b1);
    run_op(5'd9,  5'd5,  2'b01, 5'd4,  1'b0);
    run_op(5'b10110, 5'b01100, 2'b10, 5'b00100, 1'b0);
    run_op(5'b10110, 5'b01100, 2'b11, 5'b11110, 1'b0);
    run_op(5'd31, 5'd1,  2'b00, 5'd0,  1'b1);

    // T5: go pulses and operand changes while busy
    d0 = done_seen;
    expect_op(5'd7, 5'd9, 5'd16, 1'b0);
    @(negedge clk);
    in_a = 5'd7; in_b = 5'd9; op = 2'b00; go = 1'b1;
    @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("t5_in_read", fsm_state, 3);
    go = 1'b1; in_a = 5'd31; in_b = 5'd0; op = 2'b11;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_single_done", done_seen - d0, 1);
    check("t5_idle", busy, 0);

    // T6: one-cycle reset while in EXEC
    d0 = done_seen;
    wr_q.push_back({2'd0, 5'd3});
    wr_q.push_back({2'd1, 5'd4});
    @(negedge clk);
    in_a = 5'd3; in_b = 5'd4; op = 2'b00; go = 1'b1;
    @(posedge clk);
    @(negedge clk);
    go = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("t6_exec_state", fsm_state, 4);
    check("t6_we_forced", rf_if.we, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6_idle", busy, 0);
    check("t6_result_cleared", result, 0);
    repeat (10) @(negedge clk);
    check("t6_no_done", done_seen - d0, 0);
    check("t6_rf2_kept", rf_mem[2], 16);

    check("wr_q_drained", wr_q.size(), 0);
    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
